// File: rtl/add_mul_seq.sv
// add_mul_seq: sequential add / subtract / shift-add multiply unit with a
// valid/ready handshake on both sides. Add and subtract finish on the accept
// edge. Multiply spends one cycle per multiplier bit in MUL.
module add_mul_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t state_q, state_d;

  // The multiplicand shifts left and the multiplier shifts right each step,
  // so the bit under test is always mplier[0] and the partial product is
  // already aligned as a<<i.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               accept;
  logic [2*WIDTH-1:0] a_ext, b_ext;

  assign accept    = in_valid && (state_q == IDLE);
  assign a_ext     = {{WIDTH{1'b0}}, a};
  assign b_ext     = {{WIDTH{1'b0}}, b};
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; out_ready matters only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (op == OP_MUL) ? MUL : DONE;
      MUL:  if (cnt == CNT_W'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture at accept, one shift-add step per MUL cycle.
  // result is written only when an operation completes, so it holds through
  // DONE and afterwards until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        acc    <= '0;
        mcand  <= a_ext;
        mplier <= b;
        cnt    <= CNT_W'(WIDTH);
      end else if (op == OP_SUB) begin
        result <= a_ext - b_ext;
      end else begin
        // add and the reserved code share the zero-extended sum
        result <= a_ext + b_ext;
      end
    end else if (state_q == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) result <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_add_mul_seq.sv
// Directed bench for add_mul_seq at WIDTH=4. Inputs change and outputs are
// sampled on the falling edge; latency counts the accept edge as cycle 1.
module tb_add_mul_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     op = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;
  int lat;

  add_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand set for one edge, then wait (bounded) for out_valid.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top,
                     output int l);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    @(posedge clk);
    l = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && l < 20) begin
      @(posedge clk); l++;
      @(negedge clk);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ovld_low"}, out_valid, 0);
    chk({tag, "_inrdy"}, in_ready, 1);
  endtask

  initial begin
    // reset state, no clock edge needed
    #2;
    chk("rst_inrdy", in_ready, 1);
    chk("rst_ovld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // add 15+15 -> 0x1E, out_valid on the accept edge (1 cycle)
    run(4'd15, 4'd15, 2'b00, lat);
    chk("add_lat", lat, 1);
    chk("add_res", result, 8'h1E);
    chk("add_inrdy_done", in_ready, 0);
    release_out("add");
    chk("add_res_hold_idle", result, 8'h1E);

    // subtract, both signs
    run(4'd3, 4'd5, 2'b01, lat);
    chk("sub_lat", lat, 1);
    chk("sub_neg", result, 8'hFE);
    release_out("sub1");
    run(4'd5, 4'd3, 2'b01, lat);
    chk("sub_pos", result, 8'h02);
    release_out("sub2");

    // reserved op behaves as add
    run(4'd9, 4'd8, 2'b11, lat);
    chk("rsv_lat", lat, 1);
    chk("rsv_res", result, 8'h11);
    release_out("rsv");

    // multiply 15*15 with busy watched on every cycle
    a = 4'd15; b = 4'd15; op = 2'b10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_no_ovld", out_valid, 0);
      chk("mul_no_inrdy", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("mul_busy4", busy, 1);
    chk("mul_no_ovld4", out_valid, 0);
    chk("mul_res_old", result, 8'h11);
    @(posedge clk);
    @(negedge clk);
    chk("mul_ovld5", out_valid, 1);
    chk("mul_res", result, 8'hE1);
    release_out("mul");

    run(4'd0, 4'd9, 2'b10, lat);
    chk("mul0_lat", lat, 5);
    chk("mul0_res", result, 8'h00);
    release_out("mul0");

    // out_ready held high through MUL has no effect
    out_ready = 1'b1;
    run(4'd5, 4'd3, 2'b10, lat);
    chk("mulrdy_lat", lat, 5);
    chk("mulrdy_res", result, 8'h0F);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("mulrdy_idle", in_ready, 1);

    // backpressure after 7*6
    run(4'd7, 4'd6, 2'b10, lat);
    chk("bp_lat", lat, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = 4'd1; b = 4'd1; op = 2'b00;
      @(posedge clk);
      @(negedge clk);
      chk("bp_ovld", out_valid, 1);
      chk("bp_res", result, 8'h2A);
      chk("bp_inrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp_res_after", result, 8'h2A);

    // operands changed right after accept are ignored
    a = 4'd3; b = 4'd4; op = 2'b10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 4'd15; b = 4'd15; op = 2'b00;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("chg_lat", lat, 5);
    chk("chg_res", result, 8'h0C);
    release_out("chg");

    // abort on MUL cycle 2
    a = 4'd15; b = 4'd15; op = 2'b10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ovld", out_valid, 0);
    chk("abort_inrdy", in_ready, 1);
    chk("abort_res", result, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(4'd1, 4'd1, 2'b00, lat);
    chk("post_abort_lat", lat, 1);
    chk("post_abort_res", result, 8'h02);
    release_out("post");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("no_stale_ovld", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_mul_seq.md
ADD_MUL_SEQ -- requirements
Module: add_mul_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal values are integers >= 2.
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1), width of the iteration counter; derived, never overridden.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  operand set presented.
REQ-006 Port: in_ready  output  1  block can accept an operand set.
REQ-007 Port: a  input  WIDTH  operand A, unsigned.
REQ-008 Port: b  input  WIDTH  operand B, unsigned.
REQ-009 Port: op  input  2  operation code: 00 add, 01 subtract, 10 multiply, 11 reserved.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result  output  2*WIDTH  operation result.
REQ-013 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); no input is accepted in MUL or DONE.
REQ-016 Accept SHALL occur on a clock edge with in_valid && in_ready; a, b and op SHALL be captured only at accept, and later input changes SHALL be ignored.
REQ-017 For op=00 the block SHALL go from IDLE to DONE with result = zero-extended (a+b), including the carry at bit WIDTH.
REQ-018 For op=01 the block SHALL go from IDLE to DONE with result = (a-b) mod 2^(2*WIDTH), i.e. sign-extended two's complement.
REQ-019 For op=11 the block SHALL behave exactly as op=00.
REQ-020 For op=10 the block SHALL go from IDLE to MUL, clear the accumulator, and load the iteration counter with WIDTH.
REQ-021 Each MUL cycle SHALL perform one shift-add step on one multiplier bit, LSB first: accumulator += (b_bit ? a<<i : 0); then the counter SHALL decrement.
REQ-022 MUL SHALL transition to DONE on the edge where the counter goes from 1 to 0; result = a*b, unsigned and exact in 2*WIDTH bits.
REQ-023 Latency, measured from the accept edge to the edge that asserts out_valid: 1 cycle for add/sub/reserved; WIDTH+1 cycles for multiply.
REQ-024 out_valid SHALL equal (state==DONE); result SHALL hold stable while out_valid=1.
REQ-025 DONE SHALL transition to IDLE on the edge with out_ready=1; in_ready SHALL rise in the following cycle. There is no back-to-back overlap.
REQ-026 out_ready outside DONE SHALL have no effect.
REQ-027 result SHALL retain its last value after the DONE->IDLE transition until the next operation completes.
REQ-028 Operand edge values (0, 2^WIDTH-1) SHALL need no special handling; the arithmetic is exact for all inputs.

Reset
REQ-029 While rst=1, regardless of clk: state=IDLE, result=0, out_valid=0, busy=0, in_ready=1, counter and accumulator=0.
REQ-030 rst asserted mid-MUL or in DONE SHALL abort the operation immediately; no result is delivered for it.
REQ-031 The first accept SHALL be possible on the first clock edge after rst deasserts.

Verification (WIDTH=4)
REQ-032 Add: a=15, b=15, op=00, out_ready=1 -> out_valid rises 1 cycle after accept, result=0x1E, then in_ready=1 the next cycle.
REQ-033 Subtract: a=3, b=5, op=01 -> result=0xFE after 1 cycle; a=5, b=3 -> result=0x02.
REQ-034 Multiply: a=15, b=15, op=10 -> busy for 5 cycles, out_valid at accept+5, result=0xE1; a=0, b=9 -> result=0x00.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles after mul 7*6 -> out_valid stays 1, result stays 0x2A, in_ready stays 0, and in_valid pulses are ignored.
REQ-036 Input change and abort: change a and b on the cycle after accept of mul 3*4 -> result=0x0C; in a separate run, assert rst on MUL cycle 2 -> outputs immediately match REQ-029, and a new add 1+1 after release gives 0x02.
